// File: rtl/l2_flush_engine.sv
// l2_flush_engine: walks every L2 set in index order and writes each
// dirty, valid line back to physical memory, then clears its dirty bit.
// Array and pmem controls are decoded from the current state, so an
// asynchronous reset forces every strobe low immediately.

module l2_flush_engine #(
    parameter int s_index  = 3,
    parameter int s_offset = 5,
    parameter int s_tag    = 24,
    parameter int s_line   = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_req,
    output logic                busy,
    output logic                flush_done,
    output logic                arr_read,
    output logic [s_index-1:0]  arr_index,
    output logic                arr_load_dirty,
    output logic                arr_dirty_in,
    input  logic                arr_valid_out,
    input  logic                arr_dirty_out,
    input  logic [s_tag-1:0]    arr_tag_out,
    input  logic [s_line-1:0]   arr_data_out,
    output logic                pmem_write,
    output logic [31:0]         pmem_address,
    output logic [s_line-1:0]   pmem_wdata,
    input  logic                pmem_resp
);

    localparam int num_sets = 2 ** s_index;
    localparam logic [s_index-1:0] last_set  = s_index'(num_sets - 1);
    localparam logic [s_index-1:0] index_one = s_index'(1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WRITE,
        CLEAN,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [s_index-1:0]  counter;
    logic [s_index-1:0]  counter_next;
    logic [s_tag-1:0]    tag_q;
    logic [s_line-1:0]   data_q;

    // The set index is always presented; the dirty array is only ever cleared.
    assign arr_index    = counter;
    assign arr_dirty_in = 1'b0;

    // State and set-counter registers; reset abandons any walk in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    // Hold the line read in CHECK so the write-back stays stable while
    // the array outputs are free to change during WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q  <= '0;
            data_q <= '0;
        end else if (state == CHECK) begin
            tag_q  <= arr_tag_out;
            data_q <= arr_data_out;
        end
    end

    // Next-state and output decode; the last set always exits to DONE so
    // the counter never wraps.
    always_comb begin
        state_next     = state;
        counter_next   = counter;
        busy           = 1'b0;
        flush_done     = 1'b0;
        arr_read       = 1'b0;
        arr_load_dirty = 1'b0;
        pmem_write     = 1'b0;
        pmem_address   = '0;
        pmem_wdata     = '0;

        case (state)
            IDLE: begin
                if (flush_req) begin
                    counter_next = '0;
                    state_next   = READ;
                end
            end

            READ: begin
                busy       = 1'b1;
                arr_read   = 1'b1;
                state_next = CHECK;
            end

            CHECK: begin
                busy = 1'b1;
                if (arr_valid_out && arr_dirty_out) begin
                    state_next = WRITE;
                end else if (counter == last_set) begin
                    state_next = DONE;
                end else begin
                    counter_next = counter + index_one;
                    state_next   = READ;
                end
            end

            WRITE: begin
                busy         = 1'b1;
                pmem_write   = 1'b1;
                pmem_address = {tag_q, counter, {s_offset{1'b0}}};
                pmem_wdata   = data_q;
                if (pmem_resp) begin
                    state_next = CLEAN;
                end
            end

            CLEAN: begin
                busy           = 1'b1;
                arr_load_dirty = 1'b1;
                if (counter == last_set) begin
                    state_next = DONE;
                end else begin
                    counter_next = counter + index_one;
                    state_next   = READ;
                end
            end

            DONE: begin
                flush_done = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_l2_flush_engine.sv
// tb_l2_flush_engine: drives l2_flush_engine against a behavioural model of
// the L2 arrays and a pmem responder, and compares each walk against the
// expected list of write-backs and the final dirty bits.

module tb_l2_flush_engine;

    localparam int NSETS  = 8;
    localparam int BUDGET = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_req;
    logic          busy;
    logic          flush_done;
    logic          arr_read;
    logic [2:0]    arr_index;
    logic          arr_load_dirty;
    logic          arr_dirty_in;
    logic          arr_valid_out;
    logic          arr_dirty_out;
    logic [23:0]   arr_tag_out;
    logic [255:0]  arr_data_out;
    logic          pmem_write;
    logic [31:0]   pmem_address;
    logic [255:0]  pmem_wdata;
    logic          pmem_resp;

    // Array contents seen by the engine
    bit            mem_valid [NSETS];
    bit            mem_dirty [NSETS];
    logic [23:0]   mem_tag   [NSETS];
    logic [255:0]  mem_data  [NSETS];

    // Expected results of one walk
    logic [31:0]   exp_addr_q [$];
    logic [255:0]  exp_data_q [$];
    int            exp_clean_q [$];
    bit            exp_dirty [NSETS];

    // Observations of one walk
    logic [31:0]   obs_addr_q [$];
    logic [255:0]  obs_data_q [$];
    int            obs_clean_q [$];
    int            read_q [$];
    int            read_cyc_q [$];
    int            busy_err;
    int            unstable;
    int            early_exit;
    int            dirty_in_err;
    int            done_count;
    int            done_cycle;
    bit            timed_out;

    bit            hold_req;
    int            force_plan;
    bit            aborted;
    logic [255:0]  pattern;

    int            compared;
    int            mismatched;

    l2_flush_engine dut (
        .clk            (clk),
        .rst            (rst),
        .flush_req      (flush_req),
        .busy           (busy),
        .flush_done     (flush_done),
        .arr_read       (arr_read),
        .arr_index      (arr_index),
        .arr_load_dirty (arr_load_dirty),
        .arr_dirty_in   (arr_dirty_in),
        .arr_valid_out  (arr_valid_out),
        .arr_dirty_out  (arr_dirty_out),
        .arr_tag_out    (arr_tag_out),
        .arr_data_out   (arr_data_out),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic fill_clean();
        for (int i = 0; i < NSETS; i++) begin
            mem_valid[i] = 1'b1;
            mem_dirty[i] = 1'b0;
            mem_tag[i]   = 24'($urandom);
            mem_data[i]  = rand_line();
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NSETS; i++) begin
            mem_valid[i] = bit'($urandom_range(0, 1));
            mem_dirty[i] = bit'($urandom_range(0, 1));
            mem_tag[i]   = 24'($urandom);
            mem_data[i]  = rand_line();
        end
    endtask

    // Expected write-backs: every valid and dirty set, in index order.
    task automatic build_expectation();
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_clean_q.delete();
        for (int i = 0; i < NSETS; i++) begin
            if (mem_valid[i] && mem_dirty[i]) begin
                exp_addr_q.push_back((32'(mem_tag[i]) << 8) | (32'(i) << 5));
                exp_data_q.push_back(mem_data[i]);
                exp_clean_q.push_back(i);
            end
            exp_dirty[i] = mem_dirty[i] && !mem_valid[i];
        end
    endtask

    // Runs one walk cycle by cycle, acting as array and pmem responder.
    task automatic apply_stimulus(input bit start, input bit noisy, input int abort_at);
        int           cycle;
        int           wcnt;
        int           plan;
        logic [31:0]  a0;
        logic [255:0] d0;
        bit           s_read;
        bit           s_load;
        bit           s_din;
        logic [2:0]   s_idx;
        cycle = 0; wcnt = 0; plan = 0; a0 = '0; d0 = '0;
        aborted = 1'b0; timed_out = 1'b1;
        obs_addr_q.delete(); obs_data_q.delete(); obs_clean_q.delete();
        read_q.delete(); read_cyc_q.delete();
        busy_err = 0; unstable = 0; early_exit = 0; dirty_in_err = 0;
        done_count = 0; done_cycle = 0;
        if (start) begin
            @(negedge clk);
            flush_req = 1'b1;
            @(posedge clk);
            #1;
        end
        while (cycle < BUDGET) begin
            @(negedge clk);
            cycle++;
            flush_req = hold_req ? 1'b1 : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
            pmem_resp = 1'b0;
            if (!flush_done && busy !== 1'b1) busy_err++;
            if (flush_done && busy !== 1'b0) busy_err++;
            s_read = arr_read;
            s_load = arr_load_dirty;
            s_din  = arr_dirty_in;
            s_idx  = arr_index;
            if (s_read) begin
                read_q.push_back(int'(arr_index));
                read_cyc_q.push_back(cycle);
            end
            if (s_load) begin
                obs_clean_q.push_back(int'(arr_index));
                if (arr_dirty_in !== 1'b0) dirty_in_err++;
            end
            if (pmem_write) begin
                if (abort_at >= 0 && int'(arr_index) == abort_at) begin
                    aborted = 1'b1;
                    timed_out = 1'b0;
                    return;
                end
                if (wcnt == 0) begin
                    a0 = pmem_address;
                    d0 = pmem_wdata;
                    plan = (force_plan > 0) ? force_plan : int'($urandom_range(1, 4));
                end else if (pmem_address !== a0 || pmem_wdata !== d0) begin
                    unstable++;
                end
                wcnt++;
                if (wcnt == plan) begin
                    pmem_resp = 1'b1;
                    obs_addr_q.push_back(a0);
                    obs_data_q.push_back(d0);
                    wcnt = 0;
                end
            end else begin
                if (wcnt != 0) early_exit++;
                wcnt = 0;
                if (noisy) pmem_resp = 1'($urandom_range(0, 1));
            end
            if (flush_done) begin
                done_count++;
                done_cycle = cycle;
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            if (s_read) begin
                arr_valid_out = mem_valid[s_idx];
                arr_dirty_out = mem_dirty[s_idx];
                arr_tag_out   = mem_tag[s_idx];
                arr_data_out  = mem_data[s_idx];
            end
            if (s_load) mem_dirty[s_idx] = s_din;
        end
    endtask

    // Compares a completed walk against the expectation built before it.
    task automatic check_walk(input string tag);
        logic [31:0] order;
        logic [7:0]  dirty_now;
        logic [7:0]  dirty_exp;
        check_output({tag, "_timeout"}, 256'(timed_out), 256'(0));
        check_output({tag, "_done_count"}, 256'(done_count), 256'(1));
        check_output({tag, "_reads"}, 256'(read_q.size()), 256'(NSETS));
        order = '0;
        for (int i = 0; i < read_q.size() && i < NSETS; i++) order[i*4 +: 4] = 4'(read_q[i]);
        check_output({tag, "_read_order"}, 256'(order), 256'(32'h76543210));
        check_output({tag, "_writes"}, 256'(obs_addr_q.size()), 256'(exp_addr_q.size()));
        for (int i = 0; i < obs_addr_q.size() && i < exp_addr_q.size(); i++) begin
            check_output($sformatf("%s_addr%0d", tag, i), 256'(obs_addr_q[i]), 256'(exp_addr_q[i]));
            check_output($sformatf("%s_data%0d", tag, i), obs_data_q[i], exp_data_q[i]);
        end
        check_output({tag, "_cleans"}, 256'(obs_clean_q.size()), 256'(exp_clean_q.size()));
        for (int i = 0; i < obs_clean_q.size() && i < exp_clean_q.size(); i++)
            check_output($sformatf("%s_clean%0d", tag, i), 256'(obs_clean_q[i]), 256'(exp_clean_q[i]));
        for (int i = 0; i < NSETS; i++) begin
            dirty_now[i] = mem_dirty[i];
            dirty_exp[i] = exp_dirty[i];
        end
        check_output({tag, "_dirty_bits"}, 256'(dirty_now), 256'(dirty_exp));
        check_output({tag, "_busy"}, 256'(busy_err), 256'(0));
        check_output({tag, "_stable"}, 256'(unstable), 256'(0));
        check_output({tag, "_early_exit"}, 256'(early_exit), 256'(0));
        check_output({tag, "_dirty_in"}, 256'(dirty_in_err), 256'(0));
    endtask

    // After DONE the engine must settle in IDLE and not start a queued walk.
    task automatic check_idle(input string tag);
        @(negedge clk);
        flush_req = 1'b0;
        pmem_resp = 1'b0;
        check_output({tag, "_idle_busy"}, 256'(busy), 256'(0));
        check_output({tag, "_idle_done"}, 256'(flush_done), 256'(0));
        @(negedge clk);
        check_output({tag, "_no_requeue"}, 256'({busy, arr_read, pmem_write}), 256'(0));
    endtask

    initial begin
        compared = 0; mismatched = 0;
        rst = 1'b0; flush_req = 1'b0; pmem_resp = 1'b0;
        arr_valid_out = 1'b0; arr_dirty_out = 1'b0;
        arr_tag_out = '0; arr_data_out = '0;
        hold_req = 1'b0; force_plan = 0;

        // Asynchronous reset before any clock edge
        #3 rst = 1'b1;
        #1;
        check_output("rst_busy", 256'(busy), 256'(0));
        check_output("rst_strobes", 256'({flush_done, arr_read, arr_load_dirty, pmem_write, arr_dirty_in}), 256'(0));
        check_output("rst_index", 256'(arr_index), 256'(0));
        check_output("rst_address", 256'(pmem_address), 256'(0));
        check_output("rst_wdata", pmem_wdata, 256'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // All sets clean: reads on alternate cycles, done in cycle 17
        fill_clean();
        build_expectation();
        apply_stimulus(1'b1, 1'b0, -1);
        check_walk("clean");
        check_output("clean_done_cycle", 256'(done_cycle), 256'(2 * NSETS + 1));
        for (int i = 0; i < read_cyc_q.size(); i++)
            check_output($sformatf("clean_read_cycle%0d", i), 256'(read_cyc_q[i]), 256'(2 * i + 1));
        check_idle("clean");

        // Single dirty line at set 5, acknowledged on the third WRITE cycle
        fill_clean();
        pattern = 256'h0123456789ABCDEF_FEDCBA9876543210_A5A5A5A5_5A5A5A5A_DEADBEEF_CAFEF00D;
        mem_dirty[5] = 1'b1;
        mem_tag[5]   = 24'hABCDEF;
        mem_data[5]  = pattern;
        force_plan   = 3;
        build_expectation();
        apply_stimulus(1'b1, 1'b0, -1);
        force_plan   = 0;
        check_walk("set5");
        if (obs_addr_q.size() == 1) begin
            check_output("set5_address", 256'(obs_addr_q[0]), 256'(32'hABCDEFA0));
            check_output("set5_wdata", obs_data_q[0], pattern);
        end else begin
            check_output("set5_write_seen", 256'(obs_addr_q.size()), 256'(1));
        end
        check_output("set5_dirty_after", 256'(mem_dirty[5]), 256'(0));
        check_idle("set5");

        // Last set dirty: CLEAN goes straight to DONE
        fill_clean();
        mem_dirty[7] = 1'b1;
        build_expectation();
        apply_stimulus(1'b1, 1'b0, -1);
        check_walk("set7");
        check_idle("set7");

        // Invalid but dirty line is skipped and keeps its dirty bit
        fill_clean();
        mem_valid[2] = 1'b0;
        mem_dirty[2] = 1'b1;
        build_expectation();
        apply_stimulus(1'b1, 1'b0, -1);
        check_walk("inv2");
        check_idle("inv2");

        // Randomized contents, requests and spurious acknowledges
        for (int r = 0; r < 6; r++) begin
            fill_random();
            build_expectation();
            apply_stimulus(1'b1, 1'b1, -1);
            check_walk($sformatf("rand%0d", r));
            check_idle($sformatf("rand%0d", r));
        end

        // Request held high: a new walk starts right after returning to IDLE
        fill_random();
        build_expectation();
        hold_req = 1'b1;
        apply_stimulus(1'b1, 1'b0, -1);
        check_walk("hold");
        @(negedge clk);
        check_output("hold_idle_gap", 256'(busy), 256'(0));
        hold_req = 1'b0;
        build_expectation();
        apply_stimulus(1'b0, 1'b0, -1);
        check_walk("hold_restart");
        check_output("hold_restart_cycle", 256'(read_cyc_q.size() > 0 ? read_cyc_q[0] : 0), 256'(1));
        check_idle("hold_restart");

        // Reset in the middle of a write-back on set 3
        fill_clean();
        mem_dirty[3] = 1'b1;
        apply_stimulus(1'b1, 1'b0, 3);
        check_output("abort_reached", 256'(aborted), 256'(1));
        #2 rst = 1'b1;
        #1;
        check_output("abort_pmem_write", 256'(pmem_write), 256'(0));
        check_output("abort_busy", 256'(busy), 256'(0));
        check_output("abort_address", 256'(pmem_address), 256'(0));
        check_output("abort_index", 256'(arr_index), 256'(0));
        check_output("abort_dirty3", 256'(mem_dirty[3]), 256'(1));
        @(negedge clk);
        rst = 1'b0;
        flush_req = 1'b0;
        build_expectation();
        apply_stimulus(1'b1, 1'b0, -1);
        check_walk("after_abort");
        check_idle("after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
